// File: rtl/t01_alu_pkg.sv
// Shared ALU opcode encodings and arbiter FSM states for the t01 ALU slice.
package t01_alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'b0000,
    SUB = 4'b1000,
    SLL = 4'b0001,
    SLT = 4'b0010,
    XOR = 4'b0100,
    SRL = 4'b0101,
    SRA = 4'b1101,
    OR  = 4'b0110,
    AND = 4'b0111,
    LUI = 4'b0011
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/t01_rr_arbiter.sv
// Combinational round-robin pick: the first valid requester after last_grant,
// wrapping at N_REQ.
module t01_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int GID_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [GID_W-1:0] grant_idx,
  output logic             any_valid
);

  // Distance of requester i from the slot just after last_grant; smaller wins.
  function automatic int rr_dist(input int i, input int lg);
    int d;
    d = i - lg - 1;
    if (d < 0) d = d + N_REQ;
    return d;
  endfunction

  always_comb begin
    int best;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    best      = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (rr_dist(i, int'(last_grant)) < best)) begin
        best      = rr_dist(i, int'(last_grant));
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = GID_W'(i);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t01_alu_arbiter.sv
// Shares one external combinational ALU between N_REQ requesters using
// round-robin grant, registered operands and a valid/ready response channel.
module t01_alu_arbiter
  import t01_alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GID_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [4*N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_neg,
  output logic                  rsp_ovf,
  output logic [3:0]            alu_op,
  output logic [31:0]           alu_data1,
  output logic [31:0]           alu_data2,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_neg,
  input  logic                  alu_ovf,
  output logic                  busy,
  output logic [GID_W-1:0]      grant_id
);

  arb_state_t       state_q, state_d;
  logic [GID_W-1:0] last_grant_q, last_grant_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      result_q, result_d;
  logic             zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  logic [N_REQ-1:0] arb_grant;
  logic [GID_W-1:0] arb_idx;
  logic             arb_any;
  logic [3:0]       sel_op;
  logic [31:0]      sel_a, sel_b;
  logic [N_REQ-1:0] rsp_sel;

  t01_rr_arbiter #(.N_REQ(N_REQ), .GID_W(GID_W)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any_valid  (arb_any)
  );

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_op = req_op[4*i +: 4];
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    rsp_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_sel[i] = (grant_id_q == GID_W'(i));
    end
  end

  // req_ready is also held low while reset is asserted, since IDLE alone does not imply it
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    zero_d       = zero_q;
    neg_d        = neg_q;
    ovf_d        = ovf_q;
    req_ready    = '0;
    rsp_valid    = '0;
    alu_op       = ADD;
    alu_data1    = '0;
    alu_data2    = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready    = rst ? '0 : arb_grant;
          op_d         = sel_op;
          a_d          = sel_a;
          b_d          = sel_b;
          last_grant_d = arb_idx;
          grant_id_d   = arb_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        alu_op    = op_q;
        alu_data1 = a_q;
        alu_data2 = b_q;
        result_d  = alu_result;
        zero_d    = alu_zero;
        neg_d     = alu_neg;
        ovf_d     = alu_ovf;
        state_d   = RESP;
      end
      RESP: begin
        rsp_valid = rsp_sel;
        if (|(rsp_ready & rsp_sel)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GID_W'(N_REQ - 1);
      grant_id_q   <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      neg_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      neg_q        <= neg_d;
      ovf_q        <= ovf_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_neg    = neg_q;
  assign rsp_ovf    = ovf_q;

endmodule

// File: doc/t01_alu_arbiter.md
Name: t01_alu_arbiter

Overview:
Shares the single t01_alu instance between N_REQ requesters, such as the core execute stage, the branch-compare path and the load/store address generator.
- Requesters present op/operands with a valid/ready handshake.
- Grant is round-robin; the ALU is driven from registered operands.
- Result and flags return to the granted requester through a valid/ready response channel.
- Sits between the requesters and the combinational ALU; the ALU stays external and is wired to the alu_* ports.

Parameters:
N_REQ, 2, number of requesters (legal 2..4)
GID_W, 2, width of grant index (must satisfy 2**GID_W >= N_REQ)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester request accepted (one-hot or zero)
req_op  input  4*N_REQ  packed ALU opcodes, requester i at [4i+3:4i]
req_a  input  32*N_REQ  packed Data1 operands
req_b  input  32*N_REQ  packed Data2 operands
rsp_valid  output  N_REQ  per-requester response valid (one-hot or zero)
rsp_ready  input  N_REQ  per-requester response accept
rsp_result  output  32  result for the requester flagged by rsp_valid
rsp_zero  output  1  captured Zero flag
rsp_neg  output  1  captured Negative flag
rsp_ovf  output  1  captured Overflow flag
alu_op  output  4  to ALU AluOP
alu_data1  output  32  to ALU Data1
alu_data2  output  32  to ALU Data2
alu_result  input  32  from ALU AluResult
alu_zero  input  1  from ALU Zero
alu_neg  input  1  from ALU Negative
alu_ovf  input  1  from ALU Overflow
busy  output  1  high when state != IDLE
grant_id  output  GID_W  index of the current or last granted requester

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (async, rst=1) forces:
  - state=IDLE, last_grant=N_REQ-1 (so requester 0 wins first), grant_id=0;
  - operand, op and result/flag registers cleared to 0;
  - all req_ready, rsp_valid and busy low.
- IDLE:
  - If any req_valid is high, compute g = the first valid index searching from last_grant+1, wrapping at N_REQ.
  - req_ready[g] is asserted combinationally in this same cycle, and only in IDLE.
  - On the clock edge: latch req_op[g], req_a[g] and req_b[g]; set last_grant=grant_id=g; go to EXEC.
  - If no request is valid, remain in IDLE.
- EXEC:
  - alu_op/alu_data1/alu_data2 driven from the latched registers.
  - On the clock edge, capture alu_result and the three flags into the response registers; go to RESP.
- RESP:
  - rsp_valid[grant_id]=1; rsp_result and flags are stable until acceptance.
  - On rsp_ready[grant_id]=1, go to IDLE.
  - rsp_ready on other indices is ignored.
- Outside EXEC: alu_op=ADD (0000), alu_data1=alu_data2=0.
- Latency: request accepted at edge t; rsp_valid is high from t+2. Minimum occupancy is 3 cycles per operation.
- Requester behaviour:
  - A requester may drop req_valid before its grant with no effect.
  - Operands are sampled only in the grant cycle.
- Opcodes are forwarded unmodified. An undefined opcode yields result 0 with flags Z=1, N=0, V=0, exactly as the ALU returns them.
- Simultaneous rsp_ready and a new req_valid from the same requester: the response completes, and the new request is considered in the following IDLE cycle.
- Reset asserted mid-EXEC or mid-RESP: the operation is dropped with no response, and arbitration restarts at requester 0.
- Width rules: all data is 32 bits with no extension or truncation. Shift amounts are the ALU's concern.

Decomposition:
- Shared package t01_alu_pkg holds:
  - alu_op_t enum: ADD=0000, SUB=1000, SLL=0001, SLT=0010, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111, LUI=0011;
  - arb_state_t enum {IDLE, EXEC, RESP}.
- t01_alu is updated to import alu_op_t.
- One natural sub-module: t01_rr_arbiter.
  - Purely combinational round-robin pick.
  - Inputs: req vector, last_grant. Outputs: one-hot grant, index, any_valid.

Test Plan:
- Single request ADD: req0 op=0000, a=5, b=7, valid at edge t -> req_ready[0] high in the t cycle, rsp_valid[0] at t+2, rsp_result=12, Z=0, N=0, V=0.
- Contention: req0 and req1 held valid continuously -> grants alternate 0,1,0,1; each waits for the other's RESP; grant_id follows.
- Backpressure: SUB a=0x80000000, b=1, rsp_ready[0] low for 5 cycles -> rsp_valid[0] stays high, result 0x7FFFFFFF held stable, V=1; returns to IDLE the cycle after rsp_ready.
- Signed compare: SLT a=0xFFFFFFFF, b=1 -> result 1; SLT a=1, b=0xFFFFFFFF -> result 0; SRA a=0x80000000, b=4 -> 0xF8000000, N=1.
- Reset mid-operation: assert rst during EXEC -> busy=0 and rsp_valid=0 immediately (async); after release, a pending req1 and req0 pair -> req0 granted first.
- Idle ALU drive and bad opcode:
  - No requests for 10 cycles -> alu_op=0000, alu_data1=alu_data2=0, busy=0.
  - Opcode 1111 -> result 0, Z=1.
